// File: rtl/cnn_state_update.sv
`default_nettype none
// ============================================================================
// Module   : cnn_state_update
// Purpose  : Forward-Euler state integrator for one CNN cell.
//            x_next = x + (-x + sum(A*y) + sum(B*u) + z) * 2^-SHIFT
//            Taps arrive serially and are summed by a single MAC.
//            Optional macro CNN_OUT_STAGE_EN registers the clamped cell
//            output y = clamp(x_next, -1, +1) alongside x_out.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_state_update #(
   parameter int WIDTH = 9,
   parameter int SW    = 2*WIDTH-1,
   parameter int TAPS  = 18,
   parameter int SHIFT = 2,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             start_ready,
   input  logic [SW-1:0]    x_in,
   input  logic [SW-1:0]    z_in,
   input  logic             tap_valid,
   output logic             tap_ready,
   input  logic [WIDTH-1:0] tap_coef,
   input  logic [SW-1:0]    tap_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SW-1:0]    x_out,
   output logic [SW-1:0]    y_out
);

   // Full-precision product width and tap counter width
   localparam int c_PW = WIDTH + SW;
   localparam int c_CW = (TAPS > 1) ? $clog2(TAPS) : 1;

   // Saturation bounds of an SW-bit signed sample, held at accumulator width
   localparam logic signed [ACC_W-1:0] c_SAT_MAX = (ACC_W)'((64'sd1 <<< (SW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_UPDATE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic signed [SW-1:0]     r_x;
   logic signed [SW-1:0]     r_z;
   logic signed [ACC_W-1:0]  r_acc;
   logic [c_CW-1:0]          r_count;
   logic [SW-1:0]            r_x_out;

   logic signed [c_PW-1:0]   w_coef_ext;
   logic signed [c_PW-1:0]   w_data_ext;
   logic signed [c_PW-1:0]   w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_x_ext;
   logic signed [ACC_W-1:0]  w_z_ext;
   logic signed [ACC_W-1:0]  w_d;
   logic signed [ACC_W-1:0]  w_s;
   logic signed [ACC_W-1:0]  w_n;
   logic signed [SW-1:0]     w_sat;
   logic                     w_last_tap;

   // Both operands are widened to the product width first, so the multiply
   // yields the exact signed product with no truncation.
   assign w_coef_ext = {{SW{tap_coef[WIDTH-1]}}, tap_coef};
   assign w_data_ext = {{WIDTH{tap_data[SW-1]}}, tap_data};
   assign w_prod     = w_coef_ext * w_data_ext;
   assign w_prod_ext = {{(ACC_W-c_PW){w_prod[c_PW-1]}}, w_prod};

   assign w_x_ext    = {{(ACC_W-SW){r_x[SW-1]}}, r_x};
   assign w_z_ext    = {{(ACC_W-SW){r_z[SW-1]}}, r_z};

   // Euler step: arithmetic shift floors toward minus infinity
   assign w_d        = r_acc - w_x_ext + w_z_ext;
   assign w_s        = w_d >>> SHIFT;
   assign w_n        = w_x_ext + w_s;

   assign w_last_tap = (r_count == c_CW'(TAPS-1));

   // Clip the new state into the representable sample range
   always_comb begin
      w_sat = w_n[SW-1:0];
      if (w_n > c_SAT_MAX) begin
         w_sat = c_SAT_MAX[SW-1:0];
      end else if (w_n < c_SAT_MIN) begin
         w_sat = c_SAT_MIN[SW-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and handshake outputs, all derived from the state
   always_comb begin
      w_next      = r_state;
      start_ready = 1'b0;
      tap_ready   = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start) begin
               w_next = S_ACCUM;
            end
         end
         S_ACCUM: begin
            tap_ready = 1'b1;
            if (tap_valid && w_last_tap) begin
               w_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_next = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Operand capture, MAC accumulation and result registration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x     <= '0;
         r_z     <= '0;
         r_acc   <= '0;
         r_count <= '0;
         r_x_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x     <= x_in;
                  r_z     <= z_in;
                  r_acc   <= '0;
                  r_count <= '0;
               end
            end
            S_ACCUM: begin
               if (tap_valid) begin
                  r_acc   <= r_acc + w_prod_ext;
                  r_count <= r_count + c_CW'(1);
               end
            end
            S_UPDATE: begin
               r_x_out <= w_sat;
            end
            default: begin
            end
         endcase
      end
   end

   assign x_out = r_x_out;

`ifdef CNN_OUT_STAGE_EN
   localparam logic signed [SW-1:0] c_ONE  = SW'(1);
   localparam logic signed [SW-1:0] c_MONE = '1;

   logic signed [SW-1:0] w_y;
   logic [SW-1:0]        r_y_out;

   // Piecewise-linear output nonlinearity in integer scaling
   always_comb begin
      w_y = w_sat;
      if (w_sat > c_ONE) begin
         w_y = c_ONE;
      end else if (w_sat < c_MONE) begin
         w_y = c_MONE;
      end
   end

   // Cell output registered together with the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_out <= '0;
      end else if (r_state == S_UPDATE) begin
         r_y_out <= w_y;
      end
   end

   assign y_out = r_y_out;
`else
   assign y_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_state_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_state_update
// Purpose  : Scoreboard bench for cnn_state_update. The driver pushes the
//            hand-computed result of each update; a negedge monitor compares
//            every cycle res_valid is high and pops on the handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_state_update;

   localparam int WIDTH = 9;
   localparam int SW    = 2*WIDTH-1;
   localparam int TAPS  = 18;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             start_ready;
   logic [SW-1:0]    x_in = '0;
   logic [SW-1:0]    z_in = '0;
   logic             tap_valid = 1'b0;
   logic             tap_ready;
   logic [WIDTH-1:0] tap_coef = '0;
   logic [SW-1:0]    tap_data = '0;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [SW-1:0]    x_out;
   logic [SW-1:0]    y_out;

   cnn_state_update #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .TAPS  (TAPS),
      .SHIFT (2),
      .ACC_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .start_ready (start_ready),
      .x_in        (x_in),
      .z_in        (z_in),
      .tap_valid   (tap_valid),
      .tap_ready   (tap_ready),
      .tap_coef    (tap_coef),
      .tap_data    (tap_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .x_out       (x_out),
      .y_out       (y_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] cf[TAPS];
   logic [SW-1:0]    dt[TAPS];

   // Expected cell output for a given saturated state
   function automatic int ey(input int v);
`ifdef CNN_OUT_STAGE_EN
      return (v > 1) ? 1 : ((v < -1) ? -1 : v);
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int x);
      exp_t e;
      e.x = x;
      e.y = ey(x);
      sb.push_back(e);
   endtask

   task automatic fill_taps(input int c, input int d);
      for (int i = 0; i < TAPS; i++) begin
         cf[i] = WIDTH'(c);
         dt[i] = SW'(d);
      end
   endtask

   // Monitor: compare the head of the scoreboard whenever a result is shown
   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result x_out=%0d required=none", $signed(x_out));
         end else begin
            chk("x_out", int'($signed(x_out)), sb[0].x);
            chk("y_out", int'($signed(y_out)), sb[0].y);
            if (res_ready) begin
               void'(sb.pop_front());
            end
         end
      end
   end

   // Start an update; a stray tap_valid in IDLE must be ignored
   task automatic begin_update(input int x, input int z);
      @(posedge clk); #1;
      x_in      = SW'(x);
      z_in      = SW'(z);
      start     = 1'b1;
      tap_valid = 1'b1;
      tap_coef  = WIDTH'(100);
      tap_data  = SW'(100);
      chk("start_ready_idle", int'(start_ready), 1);
      @(posedge clk); #1;
      start     = 1'b0;
      tap_valid = 1'b0;
      x_in      = '0;
      z_in      = '0;
      chk("tap_ready_accum", int'(tap_ready), 1);
   endtask

   // Stream ntaps taps, optionally with random gaps and a stray start pulse
   task automatic send_taps(input int ntaps, input bit gaps, input int pulse_at);
      for (int i = 0; i < ntaps; i++) begin
         int  n;
         bit  acc;
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
               tap_valid = 1'b0;
               tap_coef  = WIDTH'($urandom);
               tap_data  = SW'($urandom);
               @(posedge clk); #1;
            end
         end
         tap_valid = 1'b1;
         tap_coef  = cf[i];
         tap_data  = dt[i];
         if (i == pulse_at) begin
            start = 1'b1;
            x_in  = SW'(999);
            z_in  = SW'(999);
         end
         n   = 0;
         acc = 1'b0;
         while (!acc && n < 40) begin
            acc = tap_ready;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
         end
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL tap_timeout tap=%0d actual=not_accepted required=accepted", i);
            tap_valid = 1'b0;
            return;
         end
      end
      tap_valid = 1'b0;
   endtask

   // Wait for the result; optionally stall res_ready (with a stray start in
   // DONE) or issue the next start in the same cycle as the handshake
   task automatic wait_result(input int stall, input bit start_same, input int x2, input int z2, input int x2_exp);
      int n;
      n = 0;
      res_ready = (stall == 0);
      while (!res_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!res_valid) begin
         checks++;
         errors++;
         $display("FAIL res_timeout actual=res_valid_low required=res_valid_high");
         res_ready = 1'b1;
         return;
      end
      for (int k = 0; k < stall; k++) begin
         start = (k == 3);
         x_in  = SW'(777);
         @(posedge clk); #1;
         start = 1'b0;
         chk("res_valid_hold", int'(res_valid), 1);
         chk("start_ready_done", int'(start_ready), 0);
      end
      res_ready = 1'b1;
      if (start_same) begin
         x_in  = SW'(x2);
         z_in  = SW'(z2);
         start = 1'b1;
         chk("start_ready_handshake", int'(start_ready), 0);
         @(posedge clk); #1;
         chk("res_valid_drop", int'(res_valid), 0);
         chk("tap_ready_not_yet", int'(tap_ready), 0);
         chk("start_ready_after", int'(start_ready), 1);
         @(posedge clk); #1;
         start = 1'b0;
         x_in  = '0;
         z_in  = '0;
         chk("tap_ready_late_start", int'(tap_ready), 1);
         push(x2_exp);
      end else begin
         @(posedge clk); #1;
         chk("res_valid_drop", int'(res_valid), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start_ready", int'(start_ready), 1);
      chk("rst_tap_ready", int'(tap_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_x_out", int'($signed(x_out)), 0);
      chk("rst_y_out", int'($signed(y_out)), 0);
      rst = 1'b0;

      // Decay: d=-8, s=-2 -> 6
      fill_taps(0, 0);
      push(6);
      begin_update(8, 0);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Bias and one tap: d=3+4=7, s=1 -> 1
      fill_taps(0, 0);
      cf[0] = WIDTH'(3);
      dt[0] = SW'(1);
      push(1);
      begin_update(0, 4);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Same vector with random gaps, a stray start in ACCUM, and a 10-cycle stall
      push(1);
      begin_update(0, 4);
      send_taps(TAPS, 1'b1, 5);
      wait_result(10, 1'b0, 0, 0, 0);

      // x=3: d=-3, s=-1 (floor) -> 2; next start in the handshake cycle, x=-4 -> -3
      fill_taps(0, 0);
      push(2);
      begin_update(3, 0);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b1, -4, 0, -3);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Mixed signs: acc=-50-6=-56, d=-56-100-20=-176, s=-44 -> 56
      fill_taps(0, 0);
      cf[0]  = WIDTH'(-5);
      dt[0]  = SW'(10);
      cf[17] = WIDTH'(2);
      dt[17] = SW'(-3);
      push(56);
      begin_update(100, -20);
      send_taps(TAPS, 1'b1, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Positive saturation
      fill_taps(255, 65535);
      push(65535);
      begin_update(65535, 0);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Negative saturation
      fill_taps(-256, 65535);
      push(-65536);
      begin_update(65535, 0);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      // Reset after 7 taps, then a clean decay update
      fill_taps(5, 7);
      begin_update(8, 0);
      send_taps(7, 1'b0, -1);
      rst = 1'b1;
      #1;
      chk("midrst_res_valid", int'(res_valid), 0);
      chk("midrst_tap_ready", int'(tap_ready), 0);
      chk("midrst_start_ready", int'(start_ready), 1);
      chk("midrst_x_out", int'($signed(x_out)), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      fill_taps(0, 0);
      push(6);
      begin_update(8, 0);
      send_taps(TAPS, 1'b0, -1);
      wait_result(0, 1'b0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
